imem_loader: RTL and testbench

Byte-stream program loader, the writer side of the CPU instruction memory. It accepts a framed image over a valid/ready byte interface, assembles 16-bit instruction words and writes them sequentially into imem. The CPU is held in reset until a load completes with a good checksum. It sits between the host byte source (UART RX or bench driver) and the imem write port / cpu reset input.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the CPU instruction memory.
// It takes LEN_HI, LEN_LO, N big-endian 16-bit words and an XOR checksum
// byte, writes each word to imem as it arrives, and keeps the CPU in reset
// until a frame completes with a matching checksum.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,   // must not exceed 2**ADDR_W
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CKSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       DEPTH_L = 17'(DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [15:0]       n_w;
    logic              last_w;

    // Ready depends only on the state, so the source never sees it change mid-cycle.
    assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
    assign xfer     = in_valid && in_ready;

    // Next-state and next-output computation for the whole loader.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wl_d    = wl_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        // Word count as it will be once the LEN_LO byte lands.
        n_w     = {len_q[15:8], in_data};
        // words_loaded already counts every earlier word by the time the next
        // DATA_LO byte can arrive, so it doubles as the current word index.
        last_w  = ((17'(wl_q) + 17'd1) == {1'b0, len_q});

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    xor_d       = xor_q ^ in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = n_w;
                    xor_d = xor_q ^ in_data;
                    if (n_w == 16'd0) begin
                        state_d = S_CKSUM;
                    end else if ({1'b0, n_w} > DEPTH_L) begin
                        // Oversized image: reject before consuming any data bytes.
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    xor_d   = xor_q ^ in_data;
                    we_d    = 1'b1;
                    waddr_d = BASE + wl_q[ADDR_W-1:0];
                    wdata_d = {hi_q, in_data};
                    wl_d    = wl_q + 1'b1;
                    state_d = last_w ? S_CKSUM : S_DATA_HI;
                end
            end
            S_CKSUM: begin
                if (xfer) begin
                    if (in_data == xor_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d = S_LEN_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    wl_d    = '0;
                    xor_d   = 8'h00;
                end
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LEN_HI;
            len_q   <= 16'h0000;
            hi_q    <= 8'h00;
            xor_q   <= 8'h00;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 16'h0000;
            wl_q    <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wl_q    <= wl_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed images into imem_loader and checks the
// imem write stream and final status against a frame-level model.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 256;
    localparam int BASE_ADDR = 0;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              load_req = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [15:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;

    wq_t got_q;
    wq_t exp_q;
    bit  exp_done;
    bit  exp_err;
    int  exp_wl;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .load_req(load_req), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Collect every write strobe and check status invariants away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we === 1'b1) got_q.push_back({16'(imem_waddr), imem_wdata});
            chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
            chk("ready_vs_status", 32'(in_ready), 32'(!(done || error)));
        end
    end

    // Frame-level reference: parse the byte list directly.
    task automatic model_frame(input bq_t b);
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = {b[0], b[1]};
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_wl   = 0;
        if (n > DEPTH) begin
            exp_err = 1'b1;
        end else begin
            x = 8'h00;
            for (int i = 0; i < 2 + 2 * n; i++) x ^= b[i];
            for (int i = 0; i < n; i++)
                exp_q.push_back({16'((BASE_ADDR + i) % (1 << ADDR_W)), b[2 + 2 * i], b[3 + 2 * i]});
            exp_wl   = n;
            exp_done = (b[2 + 2 * n] == x);
            exp_err  = !exp_done;
        end
    endtask

    function automatic bq_t build(input int n, input bit bad);
        bq_t b;
        logic [7:0] x;
        logic [7:0] v;
        b.push_back(n[15:8]);
        b.push_back(n[7:0]);
        if (n <= DEPTH) begin
            for (int i = 0; i < 2 * n; i++) begin
                v = 8'($urandom);
                b.push_back(v);
            end
            x = 8'h00;
            foreach (b[i]) x ^= b[i];
            if (bad) x ^= 8'(1 + $urandom_range(254));
            b.push_back(x);
        end
        return b;
    endfunction

    // Offer bytes with random gaps; stop if the loader leaves the receive states.
    task automatic send(input bq_t b, input int gap_pct);
        int g;
        foreach (b[i]) begin
            g = 0;
            while (($urandom_range(99) < gap_pct) && (g < 20)) begin
                in_valid = 1'b0;
                g++;
                @(posedge clk); #1;
            end
            if (!in_ready) break;
            in_valid = 1'b1;
            in_data  = b[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        chk({tag, "_wl"}, 32'(words_loaded), 32'(exp_wl));
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_wr"}, got_q[i], exp_q[i]);
    endtask

    task automatic run_frame(input string tag, input bq_t b, input int gap_pct);
        got_q.delete();
        model_frame(b);
        send(b, gap_pct);
        repeat (2) @(posedge clk);
        #1;
        check_writes(tag);
        check_status(tag);
    endtask

    task automatic restart(input string tag);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk({tag, "_rq_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_rq_done"}, 32'(done), 32'd0);
        chk({tag, "_rq_err"}, 32'(error), 32'd0);
        chk({tag, "_rq_wl"}, 32'(words_loaded), 32'd0);
        chk({tag, "_rq_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_wl"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        bq_t f1, f2, f3, f4, f5, fp, fr;
        f1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h70, 8'h00, 8'h54};
        f2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h70, 8'h00, 8'h55};
        f3 = '{8'h01, 8'h01};
        f4 = '{8'h00, 8'h00, 8'h00};
        f5 = '{8'h00, 8'h01, 8'h40, 8'h05, 8'h44};
        fp = '{8'h00, 8'h02, 8'h12};
        fr = '{8'h34, 8'h70, 8'h00, 8'h54};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        check_reset("rst");

        // Nominal frame with valid held high; written data must hold afterwards.
        run_frame("s1", f1, 0);
        chk("s1_waddr_hold", 32'(imem_waddr), 32'd1);
        chk("s1_wdata_hold", 32'(imem_wdata), 32'h7000);

        restart("s6");
        run_frame("s6", f5, 0);

        restart("s2");
        run_frame("s2", f2, 0);

        restart("s3");
        run_frame("s3", f3, 0);
        restart("s3b");
        run_frame("s3b", f4, 0);

        restart("s4");
        run_frame("s4", f1, 50);

        // Reset mid-frame, then resend the whole frame.
        restart("s5");
        got_q.delete();
        send(fp, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset("s5_rst");
        chk("s5_nwr_partial", 32'(got_q.size()), 32'd0);
        run_frame("s5", f1, 0);

        // load_req in the middle of a frame has no effect.
        restart("s7");
        got_q.delete();
        model_frame(f1);
        send(fp, 0);
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        send(fr, 30);
        repeat (2) @(posedge clk);
        #1;
        check_writes("s7");
        check_status("s7");

        // Largest accepted image.
        restart("full");
        run_frame("full", build(DEPTH, 1'b0), 10);

        // Random frames: short, oversized, good and bad checksums.
        for (int k = 0; k < 12; k++) begin
            int n;
            bit bad;
            n   = ($urandom_range(4) == 0) ? DEPTH + 1 + $urandom_range(40) : $urandom_range(6);
            bad = ($urandom_range(3) == 0);
            restart("rnd");
            run_frame("rnd", build(n, bad), 50);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
